// File: rtl/filter_seq_ctrl.sv
`default_nettype none
// =============================================================================
// filter_seq_ctrl : register file and per-scan-line read/write DMA sequencer
// Rev 1.0
// =============================================================================
module filter_seq_ctrl #(
  parameter logic [15:0] REG_BASE = 16'h4000,
  parameter int          ADDR_W   = 32,
  parameter int          LEN_W    = 12
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [1:0]        RESOL,
  input  logic [15:0]       WRADDR,
  input  logic [3:0]        BYTEEN,
  input  logic              WREN,
  input  logic [31:0]       WDATA,
  input  logic [15:0]       RDADDR,
  input  logic              RDEN,
  output logic [31:0]       RDATA,
  output logic              FLT_IRQ,
  output logic              RD_REQ,
  input  logic              RD_ACK,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [LEN_W-1:0]  RD_LEN,
  input  logic              RD_DONE,
  output logic              WR_REQ,
  input  logic              WR_ACK,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [LEN_W-1:0]  WR_LEN,
  input  logic              WR_DONE,
  output logic [2:0]        COLOR
);

  localparam logic [11:0] OFS_CTRL  = 12'h000;
  localparam logic [11:0] OFS_STAT  = 12'h004;
  localparam logic [11:0] OFS_INT   = 12'h008;
  localparam logic [11:0] OFS_SRC   = 12'h00C;
  localparam logic [11:0] OFS_FRM   = 12'h010;
  localparam logic [11:0] OFS_COLOR = 12'h014;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDQ  = 3'd1,
    S_RDW  = 3'd2,
    S_WRQ  = 3'd3,
    S_WRW  = 3'd4,
    S_NXT  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic                ie;
  logic [31:0]         src_reg, frm_reg;
  logic [2:0]          color_reg;
  logic [ADDR_W-1:0]   src_ptr, dst_ptr;
  logic [LEN_W-1:0]    line_w;
  logic [10:0]         line_h, line_cnt, line_inc;
  logic [31:0]         rd_mux;
  logic                wr_hit, busy, start_acc, clr_req;
  logic [ADDR_W-1:0]   stride;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] d,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  assign wr_hit    = WREN && (WRADDR[15:12] == REG_BASE[15:12]);
  assign busy      = (state != S_IDLE);
  assign start_acc = wr_hit && (WRADDR[11:0] == OFS_CTRL) && BYTEEN[0] && WDATA[0] && !busy;
  assign clr_req   = wr_hit && (WRADDR[11:0] == OFS_INT) && BYTEEN[0] && WDATA[1];
  assign line_inc  = line_cnt + 11'd1;
  // Line pitch in bytes: four bytes per pixel.
  assign stride    = ADDR_W'({line_w, 2'b00});

  assign RD_ADDR = src_ptr;
  assign RD_LEN  = line_w;
  assign WR_ADDR = dst_ptr;
  assign WR_LEN  = line_w;

  always_ff @(posedge ACLK) begin
    if (ARST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    RD_REQ    = 1'b0;
    WR_REQ    = 1'b0;
    case (state)
      S_IDLE: if (start_acc) state_nxt = S_RDQ;
      S_RDQ: begin
        RD_REQ = 1'b1;
        if (RD_ACK) state_nxt = S_RDW;
      end
      S_RDW: if (RD_DONE) state_nxt = S_WRQ;
      S_WRQ: begin
        WR_REQ = 1'b1;
        if (WR_ACK) state_nxt = S_WRW;
      end
      S_WRW:   if (WR_DONE) state_nxt = S_NXT;
      S_NXT:   state_nxt = (line_inc < line_h) ? S_RDQ : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      ie        <= 1'b0;
      src_reg   <= '0;
      frm_reg   <= '0;
      color_reg <= '0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      line_w    <= '0;
      line_h    <= '0;
      line_cnt  <= '0;
      COLOR     <= '0;
      FLT_IRQ   <= 1'b0;
      RDATA     <= '0;
    end else begin
      if (wr_hit) begin
        case (WRADDR[11:0])
          OFS_INT:   if (BYTEEN[0]) ie <= WDATA[0];
          OFS_SRC:   src_reg <= byte_merge(src_reg, WDATA, BYTEEN);
          OFS_FRM:   frm_reg <= byte_merge(frm_reg, WDATA, BYTEEN);
          OFS_COLOR: if (BYTEEN[0]) color_reg <= WDATA[2:0];
          default: ;
        endcase
      end

      // Frame parameters are snapshotted here so register writes mid-frame only
      // affect the next frame.
      if (start_acc) begin
        src_ptr  <= ADDR_W'(src_reg);
        dst_ptr  <= ADDR_W'(frm_reg);
        COLOR    <= color_reg;
        line_cnt <= '0;
        case (RESOL)
          2'b01: begin line_w <= LEN_W'(1024); line_h <= 11'd768;  end
          2'b10: begin line_w <= LEN_W'(1280); line_h <= 11'd1024; end
          default: begin line_w <= LEN_W'(640); line_h <= 11'd480; end
        endcase
      end else if (state == S_NXT) begin
        line_cnt <= line_inc;
        src_ptr  <= src_ptr + stride;
        dst_ptr  <= dst_ptr + stride;
      end

      // Setting on DONE takes priority over a coincident clear.
      if ((state == S_DONE) && ie) FLT_IRQ <= 1'b1;
      else if (clr_req)            FLT_IRQ <= 1'b0;

      if (RDEN) RDATA <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (RDADDR[15:12] == REG_BASE[15:12]) begin
      case (RDADDR[11:0])
        OFS_STAT:  rd_mux = {31'd0, busy};
        OFS_INT:   rd_mux = {31'd0, ie};
        OFS_SRC:   rd_mux = src_reg;
        OFS_FRM:   rd_mux = frm_reg;
        OFS_COLOR: rd_mux = {29'd0, color_reg};
        default:   rd_mux = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_seq_ctrl.sv
`default_nettype none
// tb_filter_seq_ctrl : scoreboard bench driving the register bus and a DMA model
module tb_filter_seq_ctrl;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [1:0]  RESOL;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic        WREN, RDEN;
  logic [31:0] WDATA, RDATA;
  logic        FLT_IRQ, RD_REQ, RD_ACK, RD_DONE, WR_REQ, WR_ACK, WR_DONE;
  logic [31:0] RD_ADDR, WR_ADDR;
  logic [11:0] RD_LEN, WR_LEN;
  logic [2:0]  COLOR;

  always #5 ACLK = ~ACLK;

  filter_seq_ctrl #(.REG_BASE(16'h4000), .ADDR_W(32), .LEN_W(12)) dut (
    .ACLK(ACLK), .ARST(ARST), .RESOL(RESOL),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA), .FLT_IRQ(FLT_IRQ),
    .RD_REQ(RD_REQ), .RD_ACK(RD_ACK), .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_DONE(RD_DONE),
    .WR_REQ(WR_REQ), .WR_ACK(WR_ACK), .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_DONE(WR_DONE),
    .COLOR(COLOR)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [11:0] len;
  } req_t;

  req_t rd_q[$];
  req_t wr_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   both_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
    if (RD_REQ && WR_REQ) both_req = 1'b1;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
    step();
    WREN = 1'b0;
  endtask

  task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
    RDADDR = a; RDEN = 1'b1;
    step();
    RDEN = 1'b0;
    d = RDATA;
  endtask

  task automatic wait_req(input bit is_rd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (is_rd ? RD_REQ : WR_REQ) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // ev: 0 plain, 1 start+COLOR write while busy at line 5, 2 CLR on the DONE cycle,
  //     3 ARST while line 100 is requesting
  task automatic run_frame(input int w, input int h, input logic [31:0] src,
                           input logic [31:0] frm, input logic [2:0] col,
                           input int dly, input int ev, input bit exp_irq);
    req_t        e;
    bit          ok;
    logic [31:0] stride, rdat;
    rd_q.delete();
    wr_q.delete();
    both_req = 1'b0;
    stride   = w * 4;
    for (int k = 0; k < h; k++) begin
      e.len  = 12'(w);
      e.addr = src + k * stride;
      rd_q.push_back(e);
      e.addr = frm + k * stride;
      wr_q.push_back(e);
    end
    reg_write(16'h4000, 4'hf, 32'h1);
    for (int k = 0; k < h; k++) begin
      wait_req(1'b1, ok);
      if (!ok) begin
        check("rd_req_timeout", k, h);
        finish_run();
      end
      e = rd_q.pop_front();
      if (ev == 3 && k == 100) begin
        ARST = 1'b1;
        step();
        ARST = 1'b0;
        check("rst_rd_req", RD_REQ, 0);
        check("rst_wr_req", WR_REQ, 0);
        check("rst_irq", FLT_IRQ, 0);
        check("rst_color", COLOR, 0);
        reg_read(16'h4004, rdat); check("rst_busy", rdat, 0);
        reg_read(16'h400C, rdat); check("rst_src", rdat, 0);
        reg_read(16'h4010, rdat); check("rst_frm", rdat, 0);
        reg_read(16'h4014, rdat); check("rst_colreg", rdat, 0);
        reg_read(16'h4008, rdat); check("rst_int", rdat, 0);
        return;
      end
      repeat ($urandom_range(0, 3)) step();
      check("rd_req_held", RD_REQ, 1);
      check("rd_addr", RD_ADDR, e.addr);
      check("rd_len", RD_LEN, e.len);
      check("color_out", COLOR, col);
      RD_ACK = 1'b1;
      step();
      RD_ACK = 1'b0;
      check("rd_req_drop", RD_REQ, 0);
      if (ev == 1 && k == 5) begin
        reg_write(16'h4000, 4'hf, 32'h1);
        reg_write(16'h4014, 4'hf, 32'h1);
        reg_read(16'h4004, rdat);
        check("busy_mid", rdat, 1);
      end
      for (int i = 0; i < dly; i++) begin
        WR_DONE = (k == 0 && i == 0);
        step();
      end
      WR_DONE = 1'b0;
      check("wr_req_early", WR_REQ, 0);
      RD_DONE = 1'b1;
      step();
      RD_DONE = 1'b0;

      wait_req(1'b0, ok);
      if (!ok) begin
        check("wr_req_timeout", k, h);
        finish_run();
      end
      e = wr_q.pop_front();
      repeat ($urandom_range(0, 3)) step();
      check("wr_req_held", WR_REQ, 1);
      check("wr_addr", WR_ADDR, e.addr);
      check("wr_len", WR_LEN, e.len);
      WR_ACK = 1'b1;
      step();
      WR_ACK = 1'b0;
      check("wr_req_drop", WR_REQ, 0);
      for (int i = 0; i < dly; i++) begin
        RD_DONE = (k == 0 && i == 0);
        step();
      end
      RD_DONE = 1'b0;
      check("rd_req_early", RD_REQ, 0);
      WR_DONE = 1'b1;
      step();
      WR_DONE = 1'b0;
    end
    if (ev == 2) begin
      step();
      reg_write(16'h4008, 4'hf, 32'h3);
      check("irq_set_wins", FLT_IRQ, 1);
      step();
      check("irq_set_hold", FLT_IRQ, 1);
    end else begin
      repeat (3) step();
      check("irq_end", FLT_IRQ, exp_irq);
    end
    check("no_extra_line", RD_REQ, 0);
    reg_read(16'h4004, rdat);
    check("busy_end", rdat, 0);
    check("req_overlap", both_req, 0);
  endtask

  initial begin
    logic [31:0] rdat;
    ARST = 1'b1; RESOL = 2'b00;
    WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
    RDADDR = '0; RDEN = 1'b0;
    RD_ACK = 1'b0; RD_DONE = 1'b0; WR_ACK = 1'b0; WR_DONE = 1'b0;
    repeat (3) step();
    ARST = 1'b0;
    step();

    check("reset_rd_req", RD_REQ, 0);
    check("reset_wr_req", WR_REQ, 0);
    check("reset_irq", FLT_IRQ, 0);
    check("reset_color", COLOR, 0);
    check("reset_rdata", RDATA, 0);
    check("reset_rd_addr", RD_ADDR, 0);
    check("reset_rd_len", RD_LEN, 0);
    reg_read(16'h4004, rdat); check("reset_busy", rdat, 0);

    reg_write(16'h400C, 4'hf, 32'h2000_0000);
    reg_write(16'h4010, 4'hf, 32'h2012_C000);
    reg_write(16'h4014, 4'hf, 32'h0000_0007);
    reg_write(16'h4008, 4'hf, 32'h0000_0001);
    reg_write(16'h4014, 4'h2, 32'h0000_0100);
    reg_write(16'h4018, 4'hf, 32'hFFFF_FFFF);
    reg_write(16'h500C, 4'hf, 32'hDEAD_BEEF);
    reg_read(16'h4014, rdat); check("color_be2", rdat, 32'h7);
    reg_read(16'h4010, rdat); check("frm_rb", rdat, 32'h2012_C000);
    reg_read(16'h4008, rdat); check("int_rb", rdat, 32'h1);
    reg_read(16'h4018, rdat); check("unmapped_rd", rdat, 32'h0);
    reg_read(16'h4000, rdat); check("ctrl_rd", rdat, 32'h0);
    reg_write(16'h400C, 4'h4, 32'h00AB_0000);
    reg_read(16'h400C, rdat); check("src_be4", rdat, 32'h20AB_0000);
    reg_write(16'h400C, 4'hf, 32'h2000_0000);
    reg_read(16'h400C, rdat); check("src_rb", rdat, 32'h2000_0000);
    repeat (2) step();
    check("rdata_hold", RDATA, 32'h2000_0000);

    run_frame(640, 480, 32'h2000_0000, 32'h2012_C000, 3'd7, 10, 0, 1'b1);

    reg_write(16'h4008, 4'hf, 32'h3);
    check("irq_clr", FLT_IRQ, 0);
    reg_write(16'h4008, 4'hf, 32'h0);
    run_frame(640, 480, 32'h2000_0000, 32'h2012_C000, 3'd7, 4, 1, 1'b0);

    reg_write(16'h4008, 4'hf, 32'h1);
    run_frame(640, 480, 32'h2000_0000, 32'h2012_C000, 3'd1, 4, 2, 1'b1);

    reg_write(16'h4008, 4'hf, 32'h3);
    reg_write(16'h400C, 4'hf, 32'hFFF0_0000);
    RESOL = 2'b10;
    run_frame(1280, 1024, 32'hFFF0_0000, 32'h2012_C000, 3'd1, 4, 0, 1'b1);

    reg_write(16'h4008, 4'hf, 32'h3);
    RESOL = 2'b11;
    run_frame(640, 480, 32'hFFF0_0000, 32'h2012_C000, 3'd1, 4, 0, 1'b1);

    RESOL = 2'b00;
    run_frame(640, 480, 32'hFFF0_0000, 32'h2012_C000, 3'd1, 4, 3, 1'b0);

    reg_write(16'h400C, 4'hf, 32'h1000_0000);
    reg_write(16'h4010, 4'hf, 32'h3000_0000);
    reg_write(16'h4014, 4'hf, 32'h5);
    reg_write(16'h4008, 4'hf, 32'h1);
    RESOL = 2'b01;
    run_frame(1024, 768, 32'h1000_0000, 32'h3000_0000, 3'd5, 4, 0, 1'b1);

    finish_run();
  end

endmodule
`default_nettype wire
